adder_rr_scheduler: RTL and testbench
=====================================

ADDER_RR_SCHEDULER -- requirements
Module: adder_rr_scheduler

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, operand width in bits.
REQ-002 The block SHALL have parameter NREQ, default 4, number of requesters sharing one two-input adder.
REQ-003 The block SHALL have parameter ID_W, default $clog2(NREQ), requester-tag width.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 req_valid  input  NREQ  per-requester operand pair valid.
REQ-007 req_a  input  NREQ x WIDTH  per-requester operand 0, unsigned.
REQ-008 req_b  input  NREQ x WIDTH  per-requester operand 1, unsigned.
REQ-009 req_ready  output  NREQ  one-hot grant/accept; at most one bit high per cycle.
REQ-010 res_valid  output  1  result register holds a valid sum.
REQ-011 res_data  output  WIDTH+1  registered sum including carry.
REQ-012 res_id  output  ID_W  index of the requester that produced res_data.
REQ-013 res_ready  input  1  downstream accepts the result.

Function
REQ-014 A transfer on requester i SHALL occur in a cycle where req_valid[i] and req_ready[i] are both high; output transfer when res_valid and res_ready are both high.
REQ-015 Output state machine SHALL have states EMPTY (res_valid=0) and FULL (res_valid=1).
REQ-016 The block SHALL be able to accept when state is EMPTY, or FULL with res_ready=1 (same-cycle drain and refill).
REQ-017 When able to accept and any req_valid is high, exactly one req_ready bit SHALL assert, chosen round-robin starting at ptr.
REQ-018 req_ready SHALL be combinational from req_valid, ptr, state and res_ready; it SHALL NOT depend on req_a/req_b.
REQ-019 On an accepted transfer from i, next cycle res_data SHALL equal req_a[i]+req_b[i] zero-extended to WIDTH+1 bits, res_id SHALL equal i, state SHALL be FULL.
REQ-020 Latency from input transfer to res_valid SHALL be exactly one cycle; sustained throughput one result per cycle while res_ready=1.
REQ-021 On an accepted transfer from i, ptr SHALL become (i+1) mod NREQ; with no transfer ptr SHALL hold.
REQ-022 FULL with res_ready=0: res_valid, res_data, res_id SHALL hold stable and all req_ready SHALL be 0.
REQ-023 FULL with res_ready=1 and no req_valid: state SHALL go to EMPTY.
REQ-024 EMPTY with no req_valid: state, ptr SHALL hold; res_data/res_id hold last value (don't-care).
REQ-025 Overflow: 8'hFF+8'hFF SHALL yield res_data=9'h1FE; no saturation or wrap.
REQ-026 A requester SHALL NOT be granted twice in a row while any other requester is valid (starvation bound NREQ-1 grants).

Reset
REQ-027 While rst_n=0: state=EMPTY, res_valid=0, res_data=0, res_id=0, ptr=0, req_ready=0, independent of clk.
REQ-028 Reset asserted mid-operation SHALL discard a held result immediately; first grant after release SHALL start search at requester 0.
REQ-029 Deassertion of rst_n SHALL take effect at the next rising clk edge; no grant in the cycle rst_n is low.

Structure
REQ-030 A shared package pe_pkg SHALL hold the default WIDTH, NREQ, ID_W constants and the state enum type (EMPTY, FULL).
REQ-031 Round-robin selection SHALL be a sub-module rr_arbiter (inputs req, ptr; outputs one-hot gnt, gnt_idx) reusable elsewhere in the PE.
REQ-032 The adder SHALL be inline combinational logic feeding the result register; no separate adder instance.

Verification
REQ-033 Single requester: req_valid=4'b0100, a=8'd20, b=8'd22, res_ready=1 -> req_ready=4'b0100 one cycle, next cycle res_valid=1, res_data=42, res_id=2, ptr=3.
REQ-034 All valid, res_ready=1, ptr=0 for four cycles -> grants 0,1,2,3 in order, results back-to-back, one per cycle.
REQ-035 Backpressure: result 9'd100 id 1 held, res_ready=0 three cycles with all req_valid=1 -> res_data/res_id stable, req_ready=0; on res_ready=1 grant 2 that cycle.
REQ-036 Overflow: a=8'hFF, b=8'hFF on requester 3 -> res_data=9'h1FE, res_id=3.
REQ-037 Reset mid-FULL: rst_n=0 asynchronously while res_valid=1 -> res_valid=0, ptr=0 immediately; after release all valid -> first grant to requester 0.
REQ-038 Fairness: requester 0 valid continuously, requester 1 valid continuously -> grants alternate 0,1,0,1; neither granted twice consecutively.

Source files
------------

// File: rtl/pe_pkg.sv
// ============================================================================
// Module      : pe_pkg
// Description : Shared defaults and output-state type for the PE adder scheduler.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package pe_pkg;

    localparam int PE_WIDTH = 8;
    localparam int PE_NREQ  = 4;
    localparam int PE_ID_W  = $clog2(PE_NREQ);

    typedef enum logic [0:0] {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ============================================================================
// Module      : rr_arbiter
// Description : Round-robin arbiter; search for a set request starts at ptr.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] gnt_idx
);

    logic found;
    int   idx;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = 0;
        // Walk the requesters in rotated order; the first valid one wins.
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!found && req[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                gnt_idx  = IDX_W'(idx);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/adder_rr_scheduler.sv
// ============================================================================
// Module      : adder_rr_scheduler
// Description : Shares one registered two-input adder among NREQ requesters.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module adder_rr_scheduler
    import pe_pkg::*;
#(
    parameter int WIDTH = PE_WIDTH,
    parameter int NREQ  = PE_NREQ,
    parameter int ID_W  = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    output logic [NREQ-1:0]       req_ready,
    output logic                  res_valid,
    output logic [WIDTH:0]        res_data,
    output logic [ID_W-1:0]       res_id,
    input  logic                  res_ready
);

    state_t            state_q, state_d;
    logic [ID_W-1:0]   ptr_q, ptr_d;
    logic [ID_W-1:0]   res_id_q, res_id_d;
    logic [WIDTH:0]    res_data_q, res_data_d;

    logic [NREQ-1:0]   gnt;
    logic [ID_W-1:0]   gnt_idx;
    logic              can_accept;
    logic              xfer_in;
    logic [WIDTH-1:0]  op_a, op_b;
    logic [WIDTH:0]    sum;

    rr_arbiter #(
        .N     (NREQ),
        .IDX_W (ID_W)
    ) u_arb (
        .req     (req_valid),
        .ptr     (ptr_q),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    // rst_n gates acceptance so no grant can be seen while reset is held.
    assign can_accept = rst_n && ((state_q == EMPTY) || res_ready);
    assign req_ready  = can_accept ? gnt : '0;
    assign xfer_in    = can_accept && (|req_valid);

    assign op_a = req_a[gnt_idx*WIDTH +: WIDTH];
    assign op_b = req_b[gnt_idx*WIDTH +: WIDTH];
    assign sum  = {1'b0, op_a} + {1'b0, op_b};

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        res_data_d = res_data_q;
        res_id_d   = res_id_q;

        case (state_q)
            EMPTY: begin
                if (xfer_in) state_d = FULL;
            end
            FULL: begin
                if (res_ready && !xfer_in) state_d = EMPTY;
            end
            default: state_d = EMPTY;
        endcase

        if (xfer_in) begin
            res_data_d = sum;
            res_id_d   = gnt_idx;
            ptr_d      = (gnt_idx == ID_W'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= EMPTY;
            ptr_q      <= '0;
            res_data_q <= '0;
            res_id_q   <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            res_data_q <= res_data_d;
            res_id_q   <= res_id_d;
        end
    end

    assign res_valid = (state_q == FULL);
    assign res_data  = res_data_q;
    assign res_id    = res_id_q;

endmodule

`default_nettype wire

// File: tb/tb_adder_rr_scheduler.sv
// ============================================================================
// Module      : tb_adder_rr_scheduler
// Description : Directed self-checking bench for adder_rr_scheduler.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_adder_rr_scheduler;

    localparam int WIDTH = 8;
    localparam int NREQ  = 4;
    localparam int ID_W  = 2;

    logic                  clk;
    logic                  rst_n;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic [NREQ-1:0]       req_ready;
    logic                  res_valid;
    logic [WIDTH:0]        res_data;
    logic [ID_W-1:0]       res_id;
    logic                  res_ready;

    int n_cmp  = 0;
    int n_fail = 0;

    adder_rr_scheduler #(
        .WIDTH (WIDTH),
        .NREQ  (NREQ),
        .ID_W  (ID_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .res_valid (res_valid),
        .res_data  (res_data),
        .res_id    (res_id),
        .res_ready (res_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input logic [7:0] a, input logic [7:0] b);
        req_a[i*WIDTH +: WIDTH] = a;
        req_b[i*WIDTH +: WIDTH] = b;
    endtask

    task automatic reset_pulse();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        req_valid = 4'b1111;
        #2;
        n_cmp++; if (res_valid !== 1'b0)   begin n_fail++; $display("FAIL reset_valid got %b want 0", res_valid); end
        n_cmp++; if (res_data !== 9'd0)    begin n_fail++; $display("FAIL reset_data got %0d want 0", res_data); end
        n_cmp++; if (res_id !== 2'd0)      begin n_fail++; $display("FAIL reset_id got %0d want 0", res_id); end
        n_cmp++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_ready got %b want 0000", req_ready); end
        n_cmp++; if (dut.ptr_q !== 2'd0)   begin n_fail++; $display("FAIL reset_ptr got %0d want 0", dut.ptr_q); end
        step();
        n_cmp++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_ready_clk got %b want 0000", req_ready); end
        req_valid = 4'b0000;
        rst_n     = 1'b1;
        step();
    endtask

    task automatic test_single();
        res_ready = 1'b1;
        set_op(2, 8'd20, 8'd22);
        req_valid = 4'b0100;
        #2;
        n_cmp++; if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL single_ready got %b want 0100", req_ready); end
        step();
        req_valid = 4'b0000;
        n_cmp++; if (res_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid got %b want 1", res_valid); end
        n_cmp++; if (res_data !== 9'd42) begin n_fail++; $display("FAIL single_data got %0d want 42", res_data); end
        n_cmp++; if (res_id !== 2'd2)    begin n_fail++; $display("FAIL single_id got %0d want 2", res_id); end
        n_cmp++; if (dut.ptr_q !== 2'd3) begin n_fail++; $display("FAIL single_ptr got %0d want 3", dut.ptr_q); end
        step();
        n_cmp++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL drain_empty got %b want 0", res_valid); end
    endtask

    task automatic test_back_to_back();
        logic [3:0] exp_gnt;
        reset_pulse();
        res_ready = 1'b1;
        for (int i = 0; i < NREQ; i++) set_op(i, 8'(i * 10), 8'(i + 1));
        req_valid = 4'b1111;
        for (int k = 0; k < NREQ; k++) begin
            exp_gnt = 4'b0001 << k;
            #1;
            n_cmp++; if (req_ready !== exp_gnt) begin n_fail++; $display("FAIL b2b_gnt%0d got %b want %b", k, req_ready, exp_gnt); end
            step();
            n_cmp++; if (res_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid%0d got %b want 1", k, res_valid); end
            n_cmp++; if (res_id !== 2'(k))   begin n_fail++; $display("FAIL b2b_id%0d got %0d want %0d", k, res_id, k); end
            n_cmp++; if (res_data !== 9'(k * 11 + 1)) begin n_fail++; $display("FAIL b2b_data%0d got %0d want %0d", k, res_data, k * 11 + 1); end
        end
        req_valid = 4'b0000;
        step();
        n_cmp++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drain got %b want 0", res_valid); end
    endtask

    task automatic test_backpressure();
        res_ready = 1'b1;
        set_op(1, 8'd60, 8'd40);
        req_valid = 4'b0010;
        step();
        res_ready = 1'b0;
        req_valid = 4'b1111;
        set_op(2, 8'd5, 8'd6);
        for (int k = 0; k < 3; k++) begin
            #1;
            n_cmp++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL bp_ready%0d got %b want 0000", k, req_ready); end
            n_cmp++; if (res_valid !== 1'b1)    begin n_fail++; $display("FAIL bp_valid%0d got %b want 1", k, res_valid); end
            n_cmp++; if (res_data !== 9'd100)   begin n_fail++; $display("FAIL bp_data%0d got %0d want 100", k, res_data); end
            n_cmp++; if (res_id !== 2'd1)       begin n_fail++; $display("FAIL bp_id%0d got %0d want 1", k, res_id); end
            step();
        end
        res_ready = 1'b1;
        #1;
        n_cmp++; if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL bp_release_gnt got %b want 0100", req_ready); end
        step();
        n_cmp++; if (res_data !== 9'd11) begin n_fail++; $display("FAIL bp_next_data got %0d want 11", res_data); end
        n_cmp++; if (res_id !== 2'd2)    begin n_fail++; $display("FAIL bp_next_id got %0d want 2", res_id); end
        req_valid = 4'b0000;
        step();
    endtask

    task automatic test_overflow();
        res_ready = 1'b1;
        set_op(3, 8'hFF, 8'hFF);
        req_valid = 4'b1000;
        #1;
        n_cmp++; if (req_ready !== 4'b1000) begin n_fail++; $display("FAIL ovf_gnt got %b want 1000", req_ready); end
        step();
        req_valid = 4'b0000;
        n_cmp++; if (res_data !== 9'h1FE) begin n_fail++; $display("FAIL ovf_data got %h want 1fe", res_data); end
        n_cmp++; if (res_id !== 2'd3)     begin n_fail++; $display("FAIL ovf_id got %0d want 3", res_id); end
        n_cmp++; if (dut.ptr_q !== 2'd0)  begin n_fail++; $display("FAIL ovf_ptr_wrap got %0d want 0", dut.ptr_q); end
        step();
    endtask

    task automatic test_reset_mid();
        res_ready = 1'b1;
        set_op(0, 8'd1, 8'd2);
        req_valid = 4'b0001;
        step();
        res_ready = 1'b0;
        req_valid = 4'b1111;
        #1;
        n_cmp++; if (res_valid !== 1'b1) begin n_fail++; $display("FAIL mid_full got %b want 1", res_valid); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if (res_valid !== 1'b0)    begin n_fail++; $display("FAIL mid_rst_valid got %b want 0", res_valid); end
        n_cmp++; if (dut.ptr_q !== 2'd0)    begin n_fail++; $display("FAIL mid_rst_ptr got %0d want 0", dut.ptr_q); end
        n_cmp++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL mid_rst_ready got %b want 0000", req_ready); end
        n_cmp++; if (res_data !== 9'd0)     begin n_fail++; $display("FAIL mid_rst_data got %0d want 0", res_data); end
        step();
        rst_n     = 1'b1;
        res_ready = 1'b1;
        #1;
        n_cmp++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL mid_first_gnt got %b want 0001", req_ready); end
        step();
        n_cmp++; if (res_id !== 2'd0) begin n_fail++; $display("FAIL mid_first_id got %0d want 0", res_id); end
        req_valid = 4'b0000;
        step();
    endtask

    task automatic test_fairness();
        logic [3:0] exp_gnt;
        logic [3:0] prev_gnt;
        reset_pulse();
        res_ready = 1'b1;
        set_op(0, 8'd7, 8'd0);
        set_op(1, 8'd0, 8'd9);
        req_valid = 4'b0011;
        prev_gnt  = 4'b0000;
        for (int k = 0; k < 6; k++) begin
            exp_gnt = (k % 2 == 0) ? 4'b0001 : 4'b0010;
            #1;
            n_cmp++; if (req_ready !== exp_gnt) begin n_fail++; $display("FAIL fair_gnt%0d got %b want %b", k, req_ready, exp_gnt); end
            n_cmp++; if (req_ready === prev_gnt) begin n_fail++; $display("FAIL fair_repeat%0d got %b want not %b", k, req_ready, prev_gnt); end
            prev_gnt = req_ready;
            step();
            n_cmp++; if (res_data !== ((k % 2 == 0) ? 9'd7 : 9'd9)) begin n_fail++; $display("FAIL fair_data%0d got %0d want %0d", k, res_data, (k % 2 == 0) ? 7 : 9); end
        end
        req_valid = 4'b0000;
        step();
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        res_ready = 1'b1;
        #3;
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_overflow();
        test_reset_mid();
        test_fairness();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
